if_fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of the jump/branch-prediction control.
- Owns the architectural fetch PC and drives the instruction-memory address.
- Each cycle it hands the current PC and instruction to the jump control, takes back its NPC and clr, and latches the IF instruction into ID, or a bubble when flushed.
- Runs a run/drain/halt state machine so the pipeline stops cleanly at the end of the instruction space.

---
 rtl/if_fetch_stage_pkg.sv | 21 ++
 rtl/if_fetch_stage_if_id_reg.sv | 41 ++++
 rtl/if_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, bubble word
// and PC alignment helpers.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_DRAIN = 2'd1,
    FS_HALT  = 2'd2
  } fs_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, injects a bubble, or holds.
module if_id_reg #(
  parameter logic [31:0] NOP_INS = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ins_i,
  output logic [31:0] pc_o,
  output logic [31:0] ins_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] ins_q;
  logic        valid_q;

  // Bubble wins over load so a flush can never leak a wrong-path instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= 32'h0000_0000;
      ins_q   <= NOP_INS;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      pc_q    <= pc_i;
      ins_q   <= NOP_INS;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      ins_q   <= ins_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign ins_o   = ins_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, the run/drain/halt sequencing and the
// fetch/flush counters, and feeds the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] MAX_INSADDR  = 32'hffff_fff8,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INS      = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        clr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic [31:0] id_pc,
  output logic [31:0] id_ins,
  output logic        id_valid,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  drain_q, drain_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        accept_npc;
  logic        id_load;
  logic        id_bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FS_RUN;
      pc_q        <= RESET_PC;
      drain_q     <= 4'd0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_q     <= drain_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_d     = drain_q;
    misalign_d  = misalign_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    accept_npc  = 1'b0;
    id_load     = 1'b0;
    id_bubble   = 1'b0;

    unique case (state_q)
      FS_RUN: begin
        if (clr) begin
          accept_npc  = 1'b1;
          id_bubble   = 1'b1;
          flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (!stall) begin
          id_load     = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          // The last address has no meaningful successor: stay put and drain.
          if (pc_q >= MAX_INSADDR) begin
            state_d = FS_DRAIN;
            drain_d = 4'd0;
          end else begin
            accept_npc = 1'b1;
          end
        end
      end
      FS_DRAIN: begin
        if (clr && (npc < MAX_INSADDR)) begin
          accept_npc  = 1'b1;
          id_bubble   = 1'b1;
          flush_cnt_d = flush_cnt_q + 32'd1;
          state_d     = FS_RUN;
        end else if (!stall) begin
          id_bubble = 1'b1;
          if (drain_q == DRAIN_LAST) begin
            state_d = FS_HALT;
          end else begin
            drain_d = drain_q + 4'd1;
          end
        end
      end
      FS_HALT: begin
      end
      default: begin
        state_d = FS_RUN;
      end
    endcase

    if (accept_npc) begin
      pc_d = align_pc(npc);
      if (is_misaligned(npc)) begin
        misalign_d = 1'b1;
      end
    end
  end

  if_id_reg #(
    .NOP_INS (NOP_INS)
  ) u_if_id_reg (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (id_load),
    .bubble_i (id_bubble),
    .pc_i     (pc_q),
    .ins_i    (imem_rdata),
    .pc_o     (id_pc),
    .ins_o    (id_ins),
    .valid_o  (id_valid)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ins       = (state_q == FS_RUN) ? imem_rdata : NOP_INS;
  assign halted    = (state_q == FS_HALT);
  assign misalign  = misalign_q;
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a per-cycle behavioural model and literal pins.
module tb_if_fetch_stage;

  localparam logic [31:0] MAXA = 32'hffff_fff8;
  localparam logic [31:0] NOPW = 32'h0000_0000;
  localparam int          NDRN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] npc = 32'h0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, pc, ins, id_pc, id_ins, fetch_cnt, flush_cnt;
  logic        id_valid, halted, misalign;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 = fetching, 1 = draining, 2 = stopped
  int          m_mode;
  int          m_left;
  logic [31:0] m_pc, m_idpc, m_idins, m_fc, m_flc;
  logic        m_idv, m_mis;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0] ^ 16'h1234, a[31:16] | 16'h0001};
  endfunction

  assign imem_rdata = imem_f(imem_addr);

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .npc        (npc),
    .clr        (clr),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .ins        (ins),
    .id_pc      (id_pc),
    .id_ins     (id_ins),
    .id_valid   (id_valid),
    .halted     (halted),
    .misalign   (misalign),
    .fetch_cnt  (fetch_cnt),
    .flush_cnt  (flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0;
    m_pc = 32'h0; m_idpc = 32'h0; m_idins = NOPW; m_idv = 1'b0;
    m_mis = 1'b0; m_fc = 32'h0; m_flc = 32'h0;
  endtask

  task automatic take_npc(input logic [31:0] n);
    m_pc = n & 32'hffff_fffc;
    if (n[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  task automatic model_cycle(input logic s, input logic c, input logic [31:0] n);
    if (m_mode == 2) return;
    if (c && (m_mode == 0 || n < MAXA)) begin
      m_idpc = m_pc; m_idins = NOPW; m_idv = 1'b0;
      m_flc = m_flc + 1;
      m_mode = 0;
      take_npc(n);
    end else if (s) begin
      // frozen
    end else if (m_mode == 0) begin
      m_idpc = m_pc; m_idins = imem_f(m_pc); m_idv = 1'b1;
      m_fc = m_fc + 1;
      if (m_pc >= MAXA) begin
        m_mode = 1; m_left = NDRN;
      end else begin
        take_npc(n);
      end
    end else begin
      m_idpc = m_pc; m_idins = NOPW; m_idv = 1'b0;
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("ins", ins, (m_mode == 0) ? imem_f(m_pc) : NOPW);
      chk("id_pc", id_pc, m_idpc);
      chk("id_ins", id_ins, m_idins);
      chk("id_valid", {31'h0, id_valid}, {31'h0, m_idv});
      chk("halted", {31'h0, halted}, {31'h0, (m_mode == 2)});
      chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
      chk("fetch_cnt", fetch_cnt, m_fc);
      chk("flush_cnt", flush_cnt, m_flc);
    end
  end

  task automatic step(input logic s, input logic c, input logic [31:0] n);
    stall = s; clr = c; npc = n;
    @(posedge clk);
    model_cycle(s, c, n);
    #1;
  endtask

  task automatic seq_step();
    step(1'b0, 1'b0, m_pc + 32'd4);
  endtask

  task automatic check_reset_lits(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk({tag, "_id_ins"}, id_ins, NOPW);
    chk({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
    chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
    chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'h0);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_reset_lits("rst0");
    @(posedge clk); #1;
    rst = 1'b1;
    cmp_en = 1'b1;

    seq_step();
    chk("first_pc", pc, 32'h4);
    chk("first_id_pc", id_pc, 32'h0);
    chk("first_id_ins", id_ins, 32'h2008_0005);
    chk("first_id_valid", {31'h0, id_valid}, 32'h1);
    chk("first_fetch_cnt", fetch_cnt, 32'h1);
    seq_step();

    step(1'b0, 1'b1, 32'h40);
    chk("clr_pc", pc, 32'h40);
    chk("clr_id_valid", {31'h0, id_valid}, 32'h0);
    chk("clr_id_ins", id_ins, 32'h0);
    chk("clr_id_pc", id_pc, 32'h8);
    chk("clr_flush_cnt", flush_cnt, 32'h1);
    step(1'b1, 1'b1, 32'h8);
    chk("clrstall_pc", pc, 32'h8);
    chk("clrstall_flush_cnt", flush_cnt, 32'h2);
    chk("clrstall_id_valid", {31'h0, id_valid}, 32'h0);

    seq_step();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h10);
      chk("stall_pc", pc, 32'hc);
      chk("stall_id_pc", id_pc, 32'h8);
      chk("stall_fetch_cnt", fetch_cnt, 32'h3);
    end
    step(1'b0, 1'b0, 32'h10);
    chk("unstall_id_pc", id_pc, 32'hc);
    chk("unstall_fetch_cnt", fetch_cnt, 32'h4);

    step(1'b0, 1'b0, 32'h0000_0013);
    chk("mis_pc", pc, 32'h10);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    seq_step();
    chk("mis_sticky", {31'h0, misalign}, 32'h1);

    step(1'b0, 1'b1, 32'hffff_fff0);
    for (int i = 0; i < 3; i++) seq_step();
    chk("end_id_pc", id_pc, 32'hffff_fff8);
    chk("end_pc_hold", pc, 32'hffff_fff8);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    chk("redir_pc", pc, 32'h100);
    chk("redir_halted", {31'h0, halted}, 32'h0);
    seq_step();

    step(1'b0, 1'b1, 32'hffff_fff0);
    for (int i = 0; i < 3; i++) seq_step();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("pre_halt", {31'h0, halted}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    step(1'b0, 1'b1, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    chk("halt_pc_frozen", pc, 32'hffff_fff8);
    chk("halt_id_valid", {31'h0, id_valid}, 32'h0);

    rst = 1'b0; model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 1'b1, 32'hffff_fff0);
    for (int i = 0; i < 3; i++) seq_step();
    step(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0; model_reset();
    #1;
    check_reset_lits("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    seq_step();
    chk("after_rst_pc", pc, 32'h4);
    chk("after_rst_id_pc", id_pc, 32'h0);
    chk("after_rst_id_ins", id_ins, 32'h2008_0005);
    seq_step();
    @(negedge clk); #1;
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
